// File: rtl/char_eliminator.sv
// Keyboard-driven eliminator: scans every column slot for the typed character and
// clears the matching one lowest on screen, keeping a saturating hit score.
module char_eliminator #(
  parameter int unsigned NCOL    = 640,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned OFF_W   = 9,
  parameter int unsigned SCORE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [7:0]         key_ascii,
  output logic               key_ready,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [7:0]         rd_ascii,
  input  logic               rd_active,
  input  logic [OFF_W-1:0]   rd_offset,
  output logic               clr_we,
  output logic [ADDR_W-1:0]  clr_addr,
  output logic               hit,
  output logic               miss,
  output logic [ADDR_W-1:0]  hit_col,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESULT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NCOL - 1);

  state_t             state;
  logic [7:0]         key;
  logic               best_valid;
  logic [ADDR_W-1:0]  best_slot;
  logic [OFF_W-1:0]   best_off;

  logic               cmp_en;
  logic               match;
  logic               take;
  logic [ADDR_W-1:0]  cmp_slot;
  logic               nxt_valid;
  logic [ADDR_W-1:0]  nxt_slot;
  logic [OFF_W-1:0]   nxt_off;

  function automatic logic [7:0] fold(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  // Read data lags rd_addr by one cycle, so SCAN compares slot rd_addr-1 and
  // DRAIN compares the final slot; the merged candidate feeds the RESULT decision.
  always_comb begin
    cmp_en    = (state == SCAN && rd_addr != '0) || state == DRAIN;
    cmp_slot  = (state == DRAIN) ? LAST : rd_addr - ADDR_W'(1);
    match     = rd_active && rd_ascii != 8'h00 && fold(rd_ascii) == key;
    take      = cmp_en && match && (!best_valid || rd_offset > best_off);
    nxt_valid = best_valid | take;
    nxt_slot  = take ? cmp_slot : best_slot;
    nxt_off   = take ? rd_offset : best_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      key_ready  <= 1'b1;
      rd_addr    <= '0;
      clr_we     <= 1'b0;
      clr_addr   <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      hit_col    <= '0;
      score      <= '0;
      key        <= '0;
      best_valid <= 1'b0;
      best_slot  <= '0;
      best_off   <= '0;
    end else begin
      clr_we     <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      best_valid <= nxt_valid;
      best_slot  <= nxt_slot;
      best_off   <= nxt_off;
      unique case (state)
        IDLE: begin
          if (key_valid) begin
            key        <= fold(key_ascii);
            best_valid <= 1'b0;
            key_ready  <= 1'b0;
            rd_addr    <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (rd_addr == LAST) begin
            rd_addr <= '0;
            state   <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (nxt_valid) begin
            clr_we   <= 1'b1;
            clr_addr <= nxt_slot;
            hit      <= 1'b1;
            hit_col  <= nxt_slot;
            if (score != '1) score <= score + SCORE_W'(1);
          end else begin
            miss <= 1'b1;
          end
          state <= RESULT;
        end
        RESULT: begin
          key_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_eliminator.sv
// Directed bench for char_eliminator with NCOL=8 and a 2-bit score; the RAM
// behind the read ports is a one-cycle-latency model owned by the bench.
module tb_char_eliminator;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       key_ready;
  logic [2:0] rd_addr;
  logic [7:0] rd_ascii;
  logic       rd_active;
  logic [8:0] rd_offset;
  logic       clr_we;
  logic [2:0] clr_addr;
  logic       hit;
  logic       miss;
  logic [2:0] hit_col;
  logic [1:0] score;

  logic [7:0] mem_ascii  [8];
  logic       mem_active [8];
  logic [8:0] mem_off    [8];

  int n_cmp = 0;
  int n_bad = 0;

  char_eliminator #(.NCOL(8), .ADDR_W(3), .OFF_W(9), .SCORE_W(2)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ascii(key_ascii),
    .key_ready(key_ready), .rd_addr(rd_addr), .rd_ascii(rd_ascii),
    .rd_active(rd_active), .rd_offset(rd_offset), .clr_we(clr_we),
    .clr_addr(clr_addr), .hit(hit), .miss(miss), .hit_col(hit_col), .score(score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_ascii  <= mem_ascii[rd_addr];
    rd_active <= mem_active[rd_addr];
    rd_offset <= mem_off[rd_addr];
  end

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) begin
      mem_ascii[i] = 8'h00; mem_active[i] = 1'b0; mem_off[i] = 9'd0;
    end
  endtask

  // Accept at edge T; the pulse is driven by the edge T+9 and sampled before T+10.
  task automatic run_key(input logic [7:0] k, input bit hold,
                         output logic h, output logic m, output logic cw,
                         output logic [2:0] ca, output logic [2:0] hc, output logic [1:0] sc);
    int unsigned w;
    bit early;
    w = 0;
    @(negedge clk);
    while (!key_ready && w < 50) begin @(negedge clk); w++; end
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL ready_wait: key_ready=%b required 1", key_ready); end
    key_ascii = k; key_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) key_valid = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (hit || miss || clr_we || key_ready) early = 1'b1;
    end
    n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL early_activity: early=%b required 0", early); end
    @(posedge clk); #1;
    h = hit; m = miss; cw = clr_we; ca = clr_addr; hc = hit_col; sc = score;
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL ready_in_result: key_ready=%b required 0", key_ready); end
    @(posedge clk); #1;
    n_cmp++; if ({hit, miss, clr_we} !== 3'b000) begin n_bad++; $display("FAIL pulse_width: hit/miss/clr_we=%b required 000", {hit, miss, clr_we}); end
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after: key_ready=%b required 1", key_ready); end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key_ascii = 8'h00;
    clear_mem();
    #12;
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL rst_key_ready: got %b required 1", key_ready); end
    n_cmp++; if (rd_addr !== 3'd0) begin n_bad++; $display("FAIL rst_rd_addr: got %0d required 0", rd_addr); end
    n_cmp++; if ({clr_we, hit, miss} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b required 000", {clr_we, hit, miss}); end
    n_cmp++; if (clr_addr !== 3'd0) begin n_bad++; $display("FAIL rst_clr_addr: got %0d required 0", clr_addr); end
    n_cmp++; if (hit_col !== 3'd0) begin n_bad++; $display("FAIL rst_hit_col: got %0d required 0", hit_col); end
    n_cmp++; if (score !== 2'd0) begin n_bad++; $display("FAIL rst_score: got %0d required 0", score); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic_hit();
    logic h, m, cw; logic [2:0] ca, hc; logic [1:0] sc;
    clear_mem();
    mem_ascii[3] = "A"; mem_active[3] = 1'b1; mem_off[3] = 9'd20;
    run_key("a", 1'b0, h, m, cw, ca, hc, sc);
    n_cmp++; if ({h, m, cw} !== 3'b101) begin n_bad++; $display("FAIL basic_flags: hit/miss/clr_we=%b required 101", {h, m, cw}); end
    n_cmp++; if (ca !== 3'd3) begin n_bad++; $display("FAIL basic_clr_addr: got %0d required 3", ca); end
    n_cmp++; if (hc !== 3'd3) begin n_bad++; $display("FAIL basic_hit_col: got %0d required 3", hc); end
    n_cmp++; if (sc !== 2'd1) begin n_bad++; $display("FAIL basic_score: got %0d required 1", sc); end
  endtask

  task automatic test_priority();
    logic h, m, cw; logic [2:0] ca, hc; logic [1:0] sc;
    clear_mem();
    mem_ascii[1] = "K"; mem_active[1] = 1'b1; mem_off[1] = 9'd40;
    mem_ascii[5] = "k"; mem_active[5] = 1'b1; mem_off[5] = 9'd100;
    run_key("K", 1'b0, h, m, cw, ca, hc, sc);
    n_cmp++; if ({h, cw} !== 2'b11) begin n_bad++; $display("FAIL prio_flags: hit/clr_we=%b required 11", {h, cw}); end
    n_cmp++; if (ca !== 3'd5) begin n_bad++; $display("FAIL prio_lowest: clr_addr=%0d required 5", ca); end
    n_cmp++; if (sc !== 2'd2) begin n_bad++; $display("FAIL prio_score: got %0d required 2", sc); end
    mem_off[1] = 9'd60; mem_off[5] = 9'd60;
    run_key("k", 1'b0, h, m, cw, ca, hc, sc);
    n_cmp++; if (ca !== 3'd1) begin n_bad++; $display("FAIL prio_tie: clr_addr=%0d required 1", ca); end
    n_cmp++; if (hc !== 3'd1) begin n_bad++; $display("FAIL prio_tie_col: hit_col=%0d required 1", hc); end
    n_cmp++; if (sc !== 2'd3) begin n_bad++; $display("FAIL prio_tie_score: got %0d required 3", sc); end
  endtask

  task automatic test_miss();
    logic h, m, cw; logic [2:0] ca, hc; logic [1:0] sc;
    clear_mem();
    mem_ascii[2] = "Q"; mem_active[2] = 1'b0; mem_off[2] = 9'd50;
    run_key("Q", 1'b0, h, m, cw, ca, hc, sc);
    n_cmp++; if ({h, m, cw} !== 3'b010) begin n_bad++; $display("FAIL inactive_flags: hit/miss/clr_we=%b required 010", {h, m, cw}); end
    n_cmp++; if (sc !== 2'd3) begin n_bad++; $display("FAIL inactive_score: got %0d required 3", sc); end
    n_cmp++; if (hc !== 3'd1) begin n_bad++; $display("FAIL inactive_hit_col: got %0d required 1", hc); end
    clear_mem();
    mem_ascii[4] = 8'h00; mem_active[4] = 1'b1; mem_off[4] = 9'd9;
    run_key(8'h00, 1'b0, h, m, cw, ca, hc, sc);
    n_cmp++; if ({h, m, cw} !== 3'b010) begin n_bad++; $display("FAIL null_char: hit/miss/clr_we=%b required 010", {h, m, cw}); end
  endtask

  task automatic test_back_to_back();
    logic h, m, cw; logic [2:0] ca, hc; logic [1:0] sc;
    clear_mem();
    mem_ascii[7] = "Z"; mem_active[7] = 1'b1; mem_off[7] = 9'd0;
    run_key("Z", 1'b1, h, m, cw, ca, hc, sc);
    n_cmp++; if ({h, cw} !== 2'b11) begin n_bad++; $display("FAIL drain_flags: hit/clr_we=%b required 11", {h, cw}); end
    n_cmp++; if (ca !== 3'd7) begin n_bad++; $display("FAIL drain_clr_addr: got %0d required 7", ca); end
    n_cmp++; if (sc !== 2'd3) begin n_bad++; $display("FAIL drain_score_sat: got %0d required 3", sc); end
    @(posedge clk); #1;
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL held_reaccept: key_ready=%b required 0", key_ready); end
    key_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(posedge clk); #1;
    n_cmp++; if ({hit, clr_we, clr_addr} !== {2'b11, 3'd7}) begin n_bad++; $display("FAIL held_second: hit/clr_we/clr_addr=%b required 11111", {hit, clr_we, clr_addr}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan();
    logic h, m, cw; logic [2:0] ca, hc; logic [1:0] sc;
    bit seen;
    clear_mem();
    mem_ascii[3] = "B"; mem_active[3] = 1'b1; mem_off[3] = 9'd7;
    @(negedge clk);
    key_ascii = "B"; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; #1;
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b required 1", key_ready); end
    n_cmp++; if (score !== 2'd0) begin n_bad++; $display("FAIL mid_rst_score: got %0d required 0", score); end
    n_cmp++; if ({hit, miss, clr_we, rd_addr} !== 6'd0) begin n_bad++; $display("FAIL mid_rst_outputs: got %b required 000000", {hit, miss, clr_we, rd_addr}); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (hit || miss || clr_we) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_rst_no_pulse: seen=%b required 0", seen); end
    run_key("b", 1'b0, h, m, cw, ca, hc, sc);
    n_cmp++; if ({h, cw, ca} !== {2'b11, 3'd3}) begin n_bad++; $display("FAIL post_rst_hit: hit/clr_we/clr_addr=%b required 11011", {h, cw, ca}); end
    n_cmp++; if (sc !== 2'd1) begin n_bad++; $display("FAIL post_rst_score: got %0d required 1", sc); end
  endtask

  task automatic test_saturate();
    logic h, m, cw; logic [2:0] ca, hc; logic [1:0] sc;
    logic [1:0] exp_sc [4];
    exp_sc[0] = 2'd1; exp_sc[1] = 2'd2; exp_sc[2] = 2'd3; exp_sc[3] = 2'd3;
    pulse_reset();
    clear_mem();
    mem_ascii[6] = "S"; mem_active[6] = 1'b1; mem_off[6] = 9'd5;
    for (int i = 0; i < 4; i++) begin
      run_key("s", 1'b0, h, m, cw, ca, hc, sc);
      n_cmp++; if ({h, sc} !== {1'b1, exp_sc[i]}) begin n_bad++; $display("FAIL sat_score_%0d: hit/score=%b required %b", i, {h, sc}, {1'b1, exp_sc[i]}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_priority();
    test_miss();
    test_back_to_back();
    test_reset_mid_scan();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/char_eliminator.md
Name: char_eliminator

Overview:
- Consumer side of the character display memory: the generator writes falling characters, and this block removes them when the player types.
- Accepts one typed ASCII code per handshake from the keyboard path.
- Scans every column slot of the ASCII RAM, active-column table and row-offset table, and picks the matching character lowest on screen (largest offset).
- Issues a one-cycle clear to the column table and keeps a hit score; this gives a single owned write port for keyboard-driven clears.

Parameters:
NCOL, 640, number of column slots scanned (addresses 0..NCOL-1)
ADDR_W, 10, width of the slot address (must satisfy 2^ADDR_W >= NCOL)
OFF_W, 9, width of the per-slot row offset
SCORE_W, 16, width of the hit counter

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
key_valid  input  1  typed key available
key_ascii  input  8  ASCII code of typed key, held while key_valid=1
key_ready  output  1  block can accept a key (high only in IDLE)
rd_addr  output  ADDR_W  slot address driven to the ASCII RAM, column table and offset table read ports
rd_ascii  input  8  ASCII at rd_addr, one-cycle read latency
rd_active  input  1  column-active bit at rd_addr, one-cycle read latency
rd_offset  input  OFF_W  row offset at rd_addr, one-cycle read latency
clr_we  output  1  one-cycle write strobe clearing the active bit
clr_addr  output  ADDR_W  slot to clear, valid while clr_we=1
hit  output  1  one-cycle pulse: a character was eliminated
miss  output  1  one-cycle pulse: no matching character on screen
hit_col  output  ADDR_W  slot of last hit, held until next hit
score  output  SCORE_W  count of hits

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE
  - key_ready=1
  - rd_addr=0, clr_we=0, clr_addr=0
  - hit=0, miss=0, hit_col=0, score=0
  - latched key and best-candidate registers cleared.
- FSM states: IDLE, SCAN, DRAIN, RESULT.
- Accept: in IDLE with key_valid=1 at edge T:
  - latch key_ascii, folding 'a'..'z' (8'h61..8'h7A) to upper case by subtracting 8'h20;
  - clear best_valid;
  - go to SCAN.
- SCAN: cycles T+1..T+NCOL drive rd_addr=0..NCOL-1, one address per cycle, incrementing.
  - Data for address k is compared in the following cycle.
  - After address NCOL-1, go to DRAIN.
  - rd_addr returns to 0 outside SCAN.
- DRAIN (T+NCOL+1): compare the last returned slot, then go to RESULT.
- Compare rule for a returned slot k:
  - Match when rd_active=1, rd_ascii!=0, and the case-folded rd_ascii equals the latched key.
  - A match replaces the best candidate if best_valid=0 or rd_offset > best_offset (strictly greater).
  - Ties keep the lower slot index.
- RESULT (T+NCOL+2):
  - If best_valid: clr_we=1, clr_addr=best slot, hit=1, hit_col=best slot, score+1.
  - score saturates at all-ones and does not wrap.
  - Else: miss=1, no clear.
  - Then go to IDLE; key_ready=1 from T+NCOL+3.
- Fixed latency from accept edge to hit/miss pulse: NCOL+2 cycles. One key in flight at most.
- key_valid is ignored outside IDLE. A held key_valid re-triggers a new scan on the first IDLE cycle; the upstream block must drop it after accept.
- clr_we, hit and miss are mutually exclusive with respect to hit/miss, and are high only in RESULT.
- Reset mid-scan: abort immediately, no clear, no pulse, score=0.
- The block never writes ASCII RAM or offsets. Arbitration with the generator's column-table write is outside this block.

Test Plan:
- NCOL=8; slot 3 active with 'A' at offset 20; key 'a' -> hit at T+10, clr_addr=3, hit_col=3, score=1.
- NCOL=8; slots 1 and 5 both 'K', offsets 40 and 100 -> clr_addr=5. With offsets both 60 -> clr_addr=1.
- NCOL=8; slot 2 holds 'Q' but rd_active=0; key 'Q' -> miss at T+10, clr_we stays 0, score unchanged.
- Match only at slot NCOL-1=7 (DRAIN compare) -> hit with clr_addr=7. key_valid held high during scan -> no second accept until T+11.
- Assert rst at T+4 mid-scan -> key_ready=1 at once, no hit/miss/clr_we, score=0. A new key after release scans normally.
- SCORE_W=2, four consecutive hits -> score 1,2,3,3 (saturates).
